// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving a 1-of-16 active-low select bus with a programmable break-before-make gap.
// Define ARB_TIMEOUT_EN to force-end tenures that exceed MAX_HOLD cycles and pulse TIMEOUT.
module rr_select_arbiter #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MAX_HOLD   = 64
) (
  input  logic        CLK,
  input  logic        CLRBAR,
  input  logic [15:0] REQ,
  output logic [15:0] GNT_BAR,
  output logic [3:0]  GNT_IDX,
  output logic        GNT_VALID,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  last_q, last_d;
  logic [3:0]  gap_q, gap_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [15:0] gnt_bar_q, gnt_bar_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  win_idx;
  logic        win_found;
  logic        gap_final;
  logic        arb_now;
  logic        start_grant;
  logic        req_held;
  logic        expire;
  logic        grant_end;

  // Scan from LAST+1 upward; iterating from the far end keeps the nearest hit.
  always_comb begin
    logic [3:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 15; i >= 0; i--) begin
      cand = last_q + 4'(i) + 4'd1;
      if (REQ[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign gap_final   = (state_q == S_GAP) && (gap_q == 4'(GAP_CYCLES));
  assign arb_now     = (state_q == S_IDLE) || gap_final;
  assign start_grant = arb_now && win_found;
  assign req_held    = REQ[idx_q];
  assign grant_end   = (state_q == S_GRANT) && (!req_held || expire);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold_q, hold_d;

  assign expire = (state_q == S_GRANT) && (hold_q == 16'(MAX_HOLD));

  always_comb begin
    hold_d = hold_q;
    if (start_grant)
      hold_d = 16'd1;
    else if (grant_end)
      hold_d = '0;
    else if (state_q == S_GRANT)
      hold_d = hold_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR)
      hold_q <= '0;
    else
      hold_q <= hold_d;
  end
`else
  assign expire = 1'b0;
`endif

  // State register (all registered outputs live here too)
  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR) begin
      state_q   <= S_IDLE;
      last_q    <= 4'hF;
      gap_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      gnt_bar_q <= 16'hFFFF;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      gnt_bar_q <= gnt_bar_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_grant) state_d = S_GRANT;
      S_GRANT: if (grant_end) state_d = S_GAP;
      S_GAP:   if (gap_final) state_d = win_found ? S_GRANT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    last_d    = last_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_grant) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          last_d  = win_idx;
        end
      end
      S_GRANT: begin
        if (grant_end) begin
          idx_d     = '0;
          valid_d   = 1'b0;
          gap_d     = 4'd1;
          timeout_d = req_held;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_final) begin
          gap_d = '0;
          if (start_grant) begin
            idx_d   = win_idx;
            valid_d = 1'b1;
            last_d  = win_idx;
          end
        end
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
        gap_d   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_decode
    assign gnt_bar_d[gi] = ~(valid_d && (idx_d == 4'(gi)));
  end

  assign GNT_BAR   = gnt_bar_q;
  assign GNT_IDX   = idx_q;
  assign GNT_VALID = valid_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter: reset, single request, rotation, wrap/skip, no preemption, hold timeout.
module tb_rr_select_arbiter;

  logic        CLK;
  logic        CLRBAR;
  logic [15:0] REQ;
  logic [15:0] GNT_BAR;
  logic [3:0]  GNT_IDX;
  logic        GNT_VALID;
  logic        TIMEOUT;

  int checks   = 0;
  int failures = 0;

  rr_select_arbiter #(.GAP_CYCLES(1), .MAX_HOLD(4)) dut (
    .CLK       (CLK),
    .CLRBAR    (CLRBAR),
    .REQ       (REQ),
    .GNT_BAR   (GNT_BAR),
    .GNT_IDX   (GNT_IDX),
    .GNT_VALID (GNT_VALID),
    .TIMEOUT   (TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic v, input logic [3:0] idx, input logic to);
    logic [15:0] one;
    logic [15:0] ebar;
    one  = 16'h0001;
    ebar = v ? ~(one << idx) : 16'hFFFF;
    chk({tag, ".bar"}, GNT_BAR, ebar);
    chk({tag, ".idx"}, {12'h0, GNT_IDX}, v ? {12'h0, idx} : 16'h0);
    chk({tag, ".valid"}, {15'h0, GNT_VALID}, {15'h0, v});
    chk({tag, ".timeout"}, {15'h0, TIMEOUT}, {15'h0, to});
    $display("t=%0t %s REQ=%h GNT_BAR=%h IDX=%0d VALID=%b TIMEOUT=%b", $time, tag, REQ, GNT_BAR, GNT_IDX, GNT_VALID, TIMEOUT);
  endtask

  initial begin
    logic [3:0] g;
    CLRBAR = 1'b1;
    REQ    = 16'h0000;
    #2 CLRBAR = 1'b0;
    #1 chk_gnt("reset_async", 1'b0, 4'd0, 1'b0);
    REQ = 16'hFFFF;
    tick();
    chk_gnt("reset_held", 1'b0, 4'd0, 1'b0);
    CLRBAR = 1'b1;
    tick();
    chk_gnt("first_grant", 1'b1, 4'd0, 1'b0);

    // Asynchronous reset in the middle of a clock period drops the grant at once
    #3 CLRBAR = 1'b0;
    #1 chk_gnt("reset_midgrant", 1'b0, 4'd0, 1'b0);
    tick();
    CLRBAR = 1'b1;
    tick();

    // Rotation: all requesting, each drops after its tenure and re-raises in the gap
    for (int k = 0; k <= 16; k++) begin
      g = 4'(k % 16);
      chk_gnt($sformatf("rot%0d", k), 1'b1, g, 1'b0);
      repeat (2) begin
        tick();
        chk_gnt($sformatf("rot%0d_hold", k), 1'b1, g, 1'b0);
      end
      REQ[g] = 1'b0;
      tick();
      chk_gnt($sformatf("rot%0d_gap", k), 1'b0, 4'd0, 1'b0);
      if (k < 16) begin
        REQ[g] = 1'b1;
        tick();
      end
    end
    REQ = 16'h0000;
    tick();
    chk_gnt("rot_idle", 1'b0, 4'd0, 1'b0);
    tick();
    chk_gnt("rot_idle2", 1'b0, 4'd0, 1'b0);

    // Single requester
    REQ = 16'h0020;
    tick();
    chk_gnt("single", 1'b1, 4'd5, 1'b0);
    tick();
    chk_gnt("single_hold", 1'b1, 4'd5, 1'b0);
    REQ = 16'h0000;
    tick();
    chk_gnt("single_gap", 1'b0, 4'd0, 1'b0);
    tick();
    chk_gnt("single_idle", 1'b0, 4'd0, 1'b0);

    // Wrap and skip from LAST=14
    REQ = 16'h4000;
    tick();
    chk_gnt("wrap_pre14", 1'b1, 4'd14, 1'b0);
    REQ = 16'h0000;
    tick();
    chk_gnt("wrap_gap0", 1'b0, 4'd0, 1'b0);
    REQ = 16'h0009;
    tick();
    chk_gnt("wrap_to0", 1'b1, 4'd0, 1'b0);
    REQ = 16'h0008;
    tick();
    chk_gnt("wrap_gap1", 1'b0, 4'd0, 1'b0);
    REQ = 16'h0009;
    tick();
    chk_gnt("skip_to3", 1'b1, 4'd3, 1'b0);
    REQ = 16'h0001;
    tick();
    chk_gnt("wrap_gap2", 1'b0, 4'd0, 1'b0);
    REQ = 16'h0009;
    tick();
    chk_gnt("wrap_back0", 1'b1, 4'd0, 1'b0);
    REQ = 16'h0000;
    tick();
    tick();
    chk_gnt("wrap_idle", 1'b0, 4'd0, 1'b0);

    // No preemption by a later request
    REQ = 16'h0080;
    tick();
    chk_gnt("nopre7", 1'b1, 4'd7, 1'b0);
    REQ = 16'h0084;
    repeat (3) begin
      tick();
      chk_gnt("nopre_hold7", 1'b1, 4'd7, 1'b0);
    end
    REQ = 16'h0004;
    tick();
    chk_gnt("nopre_gap", 1'b0, 4'd0, 1'b0);
    tick();
    chk_gnt("nopre2", 1'b1, 4'd2, 1'b0);
    REQ = 16'h0000;
    tick();
    tick();
    chk_gnt("nopre_idle", 1'b0, 4'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // MAX_HOLD=4: two continuous requesters alternate with timeout pulses
    REQ = 16'h0003;
    tick();
    for (int t = 0; t < 4; t++) begin
      g = 4'(t % 2);
      chk_gnt($sformatf("to%0d_start", t), 1'b1, g, 1'b0);
      repeat (3) begin
        tick();
        chk_gnt($sformatf("to%0d_hold", t), 1'b1, g, 1'b0);
      end
      tick();
      chk_gnt($sformatf("to%0d_pulse", t), 1'b0, 4'd0, 1'b1);
      tick();
    end
    chk_gnt("to_final0", 1'b1, 4'd0, 1'b0);
`else
    // Without the timeout feature a held request keeps the grant indefinitely
    REQ = 16'h0003;
    tick();
    repeat (20) begin
      chk_gnt("hold_forever0", 1'b1, 4'd0, 1'b0);
      tick();
    end
    chk_gnt("hold_forever_end", 1'b1, 4'd0, 1'b0);
`endif
    REQ = 16'h0000;
    tick();
    chk_gnt("end_gap", 1'b0, 4'd0, 1'b0);
    tick();
    chk_gnt("end_idle", 1'b0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- Round-robin arbiter that shares one 16-way active-low select bus among 16 requesters.
- Output format matches the codebase's 1-of-16 active-low decoder: at most one GNT_BAR bit low; all high when idle.
- Sits between requesting blocks and the shared resource that the scan counter/decoder pair otherwise drives.
- Enforces break-before-make, with a programmable dead gap between grants.

Parameters:
- GAP_CYCLES, 1, dead cycles (all GNT_BAR high) after each grant ends; legal range 1..15.
- MAX_HOLD, 64, maximum consecutive GRANT cycles per tenure; used only with ARB_TIMEOUT_EN; legal range 1..65535.

Ports:
- CLK  input  1  rising-edge clock.
- CLRBAR  input  1  asynchronous active-low reset; all state cleared while low.
- REQ  input  16  active-high requests; bit i = requester i; synchronous to CLK.
- GNT_BAR  output  16  active-low one-hot grant; 16'hFFFF = no grant.
- GNT_IDX  output  4  binary index of the current grant; 0 when GNT_VALID=0.
- GNT_VALID  output  1  high while any grant is active.
- TIMEOUT  output  1  one-cycle pulse when a grant is force-ended; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- One clock; reset is asynchronous and active-low (CLRBAR); the clock port is CLK.
- All outputs are registered.
- Reset (CLRBAR low), effective immediately regardless of CLK:
  - state=IDLE; GNT_BAR=16'hFFFF; GNT_IDX=0; GNT_VALID=0; TIMEOUT=0.
  - Priority pointer LAST=4'hF, so the first search starts at index 0.
  - Gap counter and hold counter = 0.
- Deassertion of CLRBAR takes effect at the next CLK edge. Reset mid-grant drops the grant the same instant (asynchronous).
- Winner search:
  - Scan indices LAST+1, LAST+2, … mod 16, wrapping 15→0.
  - The first index with REQ set wins.
  - Purely combinational from REQ and LAST; evaluated only in IDLE or on the final GAP cycle.
- State IDLE:
  - Outputs deasserted.
  - On an edge where REQ!=0: go to GRANT; GNT_BAR[w]=0, GNT_IDX=w, GNT_VALID=1, LAST=w, hold counter=1.
  - Latency: a REQ sampled high at edge N gives a grant visible immediately after edge N.
- State GRANT:
  - Outputs held stable.
  - Edge with REQ[GNT_IDX]=0: go to GAP; GNT_BAR=16'hFFFF, GNT_VALID=0, GNT_IDX=0, gap counter=1.
  - Other requesters' REQ changes are ignored during GRANT; no preemption.
- State GAP:
  - Outputs deasserted.
  - Gap counter increments each edge.
  - The edge where the gap counter equals GAP_CYCLES is the final GAP cycle; on it:
    - if REQ!=0: go straight to GRANT of the new winner (same update as in IDLE);
    - otherwise: go to IDLE.
  - Minimum spacing between grants is therefore GAP_CYCLES cycles with GNT_BAR=16'hFFFF.
- Fairness:
  - LAST is updated to each winner, so the just-served requester has lowest priority.
  - With all 16 requesting continuously, grants rotate 0,1,…,15,0.
- Single requester re-requesting: it is re-granted after the gap (it is the only candidate).
- REQ dropped and re-raised inside GAP: ignored until the final GAP cycle.
- Invariants:
  - GNT_BAR is never more than one bit low.
  - GNT_VALID equals ~&GNT_BAR.
  - GNT_BAR[GNT_IDX]=0 whenever GNT_VALID=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter increments each GRANT cycle.
  - On the edge where hold counter=MAX_HOLD and REQ[GNT_IDX] is still 1: force a transition to GAP and pulse TIMEOUT=1 for exactly one cycle, aligned with the first GAP cycle.
  - LAST stays at the evicted index, so it gets lowest priority at the next arbitration.
  - A requester that drops REQ on the same edge as expiry ends normally: no TIMEOUT pulse.
- Undefined:
  - No hold counter logic; grants last indefinitely while REQ is held.
  - TIMEOUT is constant 0.

Test Plan:
- Reset: CLRBAR=0 with REQ=16'hFFFF, applied mid-clock → GNT_BAR=16'hFFFF, GNT_VALID=0 immediately. After release, the first grant is index 0 (GNT_BAR=16'hFFFE).
- Single request: REQ=16'h0020 raised before edge N → after edge N GNT_BAR=16'hFFDF, GNT_IDX=5. REQ dropped → GAP_CYCLES(=1) cycle of 16'hFFFF, then IDLE.
- Rotation: REQ=16'hFFFF held, each requester drops REQ 3 cycles after its grant and re-raises it during the following gap → grant order 0,1,2,…,15,0. Every tenure is separated by exactly GAP_CYCLES cycles of 16'hFFFF.
- Wrap and skip: LAST=14, REQ=16'h0009 → the next grant is index 0, then index 3, then 0 again.
- No preemption: index 7 granted, REQ[2] raised mid-tenure → GNT_IDX remains 7 until REQ[7] drops; index 2 is granted after the gap.
- ARB_TIMEOUT_EN, MAX_HOLD=4: REQ=16'h0003 held → index 0 for 4 cycles, TIMEOUT pulse, gap, index 1 for 4 cycles, TIMEOUT, alternating. Without the macro: index 0 held forever and TIMEOUT stays 0.
